board_animator: RTL
===================

# board_animator

Board-side responder to the game FSM's position-update handshake. It receives `pos_valid` with the player positions and `turn`, then walks the active player's displayed token one square at a time on a fixed step interval. When the token reaches the target, it raises `turn_done` and holds it until the FSM drops `pos_valid` (4-phase handshake). It sits between the game FSM and the VGA board renderer, which draws `disp_p1_pos` and `disp_p2_pos`.

## Interface
- `STEP_CYCLES`, default 50_000_000: clk cycles per one-square hop (0.5 s at 100 MHz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `pos_valid`  in  1  level request from the game FSM; held high until `turn_done` is seen.
- `turn`  in  1  moving player: 0 = P1, 1 = P2. Captured with the request.
- `p1_pos`  in  4  P1 logical position, 0–15; values above 9 are clamped to 9.
- `p2_pos`  in  4  P2 logical position, same rules as `p1_pos`.
- `disp_p1_pos`  out  4  P1 displayed position, 0–9.
- `disp_p2_pos`  out  4  P2 displayed position, 0–9.
- `moving`  out  1  high while in S_STEP.
- `active_player`  out  1  player being animated; last captured `turn`.
- `step_tick`  out  1  one-cycle pulse on each hop.
- `turn_done`  out  1  level acknowledge.

## Operation
- Reset values: all outputs 0; state S_IDLE; step counter 0; target 0.
- `pv` is the internal `pos_valid`, synchronized when ANIM_SYNC_EN is defined. `pv_d` is `pv` delayed by one cycle. `rise = pv & ~pv_d`.
- **S_IDLE**
  - Every cycle, `disp_p1_pos` and `disp_p2_pos` snap to the clamped inputs. This tracks start-of-game and event jumps such as reset-to-0.
  - On `rise`: capture `turn` into `active_player` and `target = clamp(turn ? p2_pos : p1_pos)`. Clear the counter.
  - If `target` equals the active player's current displayed position, go to S_DONE. Otherwise go to S_STEP.
- **S_STEP**
  - The counter increments each cycle. At `STEP_CYCLES-1` it clears, pulses `step_tick`, and moves the active player's displayed position ±1 toward `target`. Backward moves are legal.
  - If that hop makes the displayed position equal `target`, go to S_DONE on the same edge.
  - Input position changes are ignored in S_STEP. The inactive player's display is frozen.
  - If `pv` falls (abort): go to S_IDLE and snap the displays. `turn_done` is never raised.
- **S_DONE**
  - `turn_done` = 1.
  - When `pv` is 0: `turn_done` goes to 0 and the next state is S_IDLE. The snap in S_IDLE then picks up any post-event correction.
- Arithmetic:
  - Positions are 4-bit unsigned.
  - Clamp: `x > 9 → 9`.
  - The counter is `$clog2(STEP_CYCLES)` bits wide and never wraps past `STEP_CYCLES-1`.
- Simultaneous events: `rise` is only acted on in S_IDLE. A `rise` seen in S_DONE cannot occur because `pv` is already high, so no new request is accepted until `pv` has been low for at least one cycle.
- Reset mid-operation: return immediately to the reset values. `turn_done` drops asynchronously.

## Timing
- `pos_valid` high at edge 0 → `rise` recognised at edge 2 with the sync, edge 0 without. The state leaves S_IDLE on that same edge.
- Entering S_STEP at edge t: hop k becomes visible after edge `t + k·STEP_CYCLES`. For N = |target − disp|, `turn_done` is high after edge `t + N·STEP_CYCLES`, together with the final hop.
- Zero distance: `turn_done` is high one cycle after `rise`.
- `pos_valid` low → `turn_done` low 3 edges later with the sync, 1 edge later without.
- `step_tick` is high for exactly one cycle per hop.

## Configuration
- **ANIM_SYNC_EN defined:**
  - `pos_valid` passes through a 2-flop synchronizer before edge detection.
  - `turn`, `p1_pos` and `p2_pos` are registered once. They are stable by protocol while `pos_valid` is high.
  - Use when the game FSM runs on a different clock.
- **Not defined:** `pos_valid` and the data are used directly, with only the `pv_d` register. Use for same-clock integration.

## Structure
- `board_anim_pkg`:
  - `state_t {S_IDLE, S_STEP, S_DONE}`
  - `POS_W = 4`
  - `MAX_POS = 9`
  - clamp function
- Sub-module `anim_step_timer`: parameter `STEP_CYCLES`; inputs `clk`, `reset`, `clear`, `en`; output `tick`. The counter described in Operation.

## Test plan
Run with `STEP_CYCLES = 4`, ANIM_SYNC_EN defined unless stated.
- **Reset:** assert `reset` mid-S_STEP → all outputs 0 within the same cycle; S_IDLE.
- **Forward move:** `disp_p1 = 0`, `turn = 0`, `p1_pos = 3`, `pos_valid = 1` → `disp_p1` reads 1, 2, 3 at 4-cycle spacing with 3 `step_tick` pulses. `turn_done` rises with the third hop and stays high until 3 cycles after `pos_valid` drops. `disp_p2` is unchanged.
- **Clamp and P2:** `turn = 1`, `p2_pos = 12` from 7 → 2 hops, ending at `disp_p2 = 9`.
- **Zero-distance request:** `p1_pos` equals `disp_p1` → `turn_done` high 1 cycle after `rise`; no `step_tick`.
- **Post-event snap:** after the handshake completes at `disp_p1 = 3`, `p1_pos` goes to 0 while `pos_valid = 0` → `disp_p1 = 0` on the next S_IDLE cycle; no `step_tick`.
- **Abort:** `pos_valid` drops after 1 hop of a 3-square move → S_IDLE, displays snapped to the inputs, `turn_done` never asserted. Without ANIM_SYNC_EN, repeat the forward-move case and check the `rise` latency is 2 cycles shorter.

Source files
------------

// File: rtl/board_anim_pkg.sv
// Shared types and helpers for the board animator: FSM states, position
// width and the display clamp.
package board_anim_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  localparam int POS_W = 4;
  localparam logic [POS_W-1:0] MAX_POS = 4'd9;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] x);
    return (x > MAX_POS) ? MAX_POS : x;
  endfunction

endpackage

// File: rtl/board_anim_step_timer.sv
// Hop interval timer: counts 0..STEP_CYCLES-1 while enabled and pulses o_tick
// on the terminal count, restarting from 0 without ever wrapping further.
module anim_step_timer #(
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en & w_last & ~i_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/board_animator.sv
// Walks the moving player's displayed token one square per hop toward the
// requested position, then acknowledges with a 4-phase turn_done. Define
// ANIM_SYNC_EN when pos_valid comes from another clock domain.
module board_animator
  import board_anim_pkg::*;
#(
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pos_valid,
  input  logic             i_turn,
  input  logic [POS_W-1:0] i_p1_pos,
  input  logic [POS_W-1:0] i_p2_pos,
  output logic [POS_W-1:0] o_disp_p1_pos,
  output logic [POS_W-1:0] o_disp_p2_pos,
  output logic             o_moving,
  output logic             o_active_player,
  output logic             o_step_tick,
  output logic             o_turn_done
);

  logic             w_pv;
  logic             w_pend;
  logic             w_turn;
  logic [POS_W-1:0] w_p1;
  logic [POS_W-1:0] w_p2;

`ifdef ANIM_SYNC_EN
  logic             r_pv_s1;
  logic             r_pv_s2;
  logic             r_turn_q;
  logic [POS_W-1:0] r_p1_q;
  logic [POS_W-1:0] r_p2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv_s1  <= 1'b0;
      r_pv_s2  <= 1'b0;
      r_turn_q <= 1'b0;
      r_p1_q   <= '0;
      r_p2_q   <= '0;
    end else begin
      r_pv_s1  <= i_pos_valid;
      r_pv_s2  <= r_pv_s1;
      r_turn_q <= i_turn;
      r_p1_q   <= i_p1_pos;
      r_p2_q   <= i_p2_pos;
    end
  end

  assign w_pv   = r_pv_s2;
  assign w_pend = r_pv_s1 | r_pv_s2;
  assign w_turn = r_turn_q;
  assign w_p1   = r_p1_q;
  assign w_p2   = r_p2_q;
`else
  assign w_pv   = i_pos_valid;
  assign w_pend = i_pos_valid;
  assign w_turn = i_turn;
  assign w_p1   = i_p1_pos;
  assign w_p2   = i_p2_pos;
`endif

  logic             r_pv_d;
  logic             w_rise;
  state_t           r_state, w_state_n;
  logic [POS_W-1:0] r_disp1, w_disp1_n;
  logic [POS_W-1:0] r_disp2, w_disp2_n;
  logic [POS_W-1:0] r_target, w_target_n;
  logic             r_active, w_active_n;
  logic             r_step_tick, w_step_tick_n;
  logic [POS_W-1:0] w_tgt_in;
  logic [POS_W-1:0] w_cur;
  logic [POS_W-1:0] w_hop;
  logic             w_tick;

  assign w_rise   = w_pv & ~r_pv_d;
  assign w_tgt_in = clamp_pos(w_turn ? w_p2 : w_p1);
  assign w_cur    = r_active ? r_disp2 : r_disp1;
  assign w_hop    = (r_target > w_cur) ? w_cur + 1'b1 : w_cur - 1'b1;

  anim_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clear(r_state != S_STEP),
    .i_en   (r_state == S_STEP),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv_d      <= 1'b0;
      r_state     <= S_IDLE;
      r_disp1     <= '0;
      r_disp2     <= '0;
      r_target    <= '0;
      r_active    <= 1'b0;
      r_step_tick <= 1'b0;
    end else begin
      r_pv_d      <= w_pv;
      r_state     <= w_state_n;
      r_disp1     <= w_disp1_n;
      r_disp2     <= w_disp2_n;
      r_target    <= w_target_n;
      r_active    <= w_active_n;
      r_step_tick <= w_step_tick_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_disp1_n     = r_disp1;
    w_disp2_n     = r_disp2;
    w_target_n    = r_target;
    w_active_n    = r_active;
    w_step_tick_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_active_n = w_turn;
          w_target_n = w_tgt_in;
          w_state_n  = (w_tgt_in == (w_turn ? r_disp2 : r_disp1)) ? S_DONE : S_STEP;
        end else if (!w_pend) begin
          // Hold the old squares while a request is in flight so the walk starts from them.
          w_disp1_n = clamp_pos(w_p1);
          w_disp2_n = clamp_pos(w_p2);
        end
      end
      S_STEP: begin
        if (!w_pv) begin
          w_state_n = S_IDLE;
        end else if (w_tick) begin
          w_step_tick_n = 1'b1;
          if (r_active) w_disp2_n = w_hop;
          else          w_disp1_n = w_hop;
          if (w_hop == r_target) w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (!w_pv) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign o_disp_p1_pos   = r_disp1;
  assign o_disp_p2_pos   = r_disp2;
  assign o_moving        = (r_state == S_STEP);
  assign o_turn_done     = (r_state == S_DONE);
  assign o_active_player = r_active;
  assign o_step_tick     = r_step_tick;

endmodule
